mem_op_executor: RTL
====================

// Module: mem_op_executor
// PURPOSE
//  Parametrised micro-op executor: on Start, latches one opcode, reads up to two operand cells over the shared
//  memory bus, computes in an internal ALU, and writes the result back to a destination cell.
//  Sits between the instruction sequencer and the single-port memory, and owns the tristate data bus while busy.
//  Adds Start/Busy/Done handshake, flags, illegal-op error and per-op step skipping.
// PARAMETERS
//  N    8    memory cell / datapath width (bits), N>=2
//  M    2    memory address width (2^M cells)
//  OPW  4+3*M  opcode width = {op[3:0], dst[M-1:0], srcA[M-1:0], srcB[M-1:0]} (localparam, not overridable)
// PORTS
//  Clock         in     1    posedge clock
//  ResetN        in     1    asynchronous, active-low reset
//  Start         in     1    request; sampled only in IDLE
//  OpCode        in     OPW  operation; latched on accepted Start
//  MemorySelect  out    M    memory address
//  MemoryData    inout  N    memory data; driven only in WRITE, else 'z
//  MemoryRW      out    1    0=read, 1=write
//  Busy          out    1    high from cycle after accepted Start until DONE inclusive
//  Done          out    1    one-cycle pulse at end of operation
//  Error         out    1    valid with Done: opcode illegal, no write performed
//  Carry, Zero   out    1    ALU flags of last completed op, held until next Done
// BEHAVIOUR
//  Reset (async): state=IDLE; MemorySelect=0, MemoryRW=0, MemoryData='z; Busy=Done=Error=Carry=Zero=0; latches 0.
//  Reset mid-operation aborts immediately; any write in progress is not completed (RW falls to 0 with reset).
//  States: IDLE -> RDA -> RDB -> EXEC -> WRITE -> DONE -> IDLE.
//   IDLE:  Start=1 -> latch OpCode, go RDA (or DONE with Error if op illegal). Start=0 -> stay.
//   RDA:   Select=srcA, RW=0; capture MemoryData into regA at clock edge (memory read is combinational).
//   RDB:   Select=srcB, RW=0; capture regB. Skipped (RDA->EXEC) for unary ops.
//   EXEC:  ALU computes result/flags from regA, regB; register result.
//   WRITE: Select=dst, RW=1, MemoryData=result for exactly one cycle; memory writes on that edge.
//   DONE:  Done=1, Busy=1, RW=0, bus 'z; update Carry/Zero (unchanged if Error); next IDLE.
//  Ops (op[3:0]): 0 NOP (no read, no write: IDLE->DONE), 1 MOV dst=A, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR,
//   7 NOT dst=~A, 8 INC dst=A+1, 9 DEC dst=A-1, A SHL dst=A<<1, B SHR dst=A>>1 (logical), C CLR dst=0 (no reads),
//   D-F illegal -> Error=1 at Done, no bus activity.
//  Unary ops (MOV,NOT,INC,DEC,SHL,SHR) skip RDB. CLR skips RDA and RDB.
//  Latency (Start edge to Done high): binary 5 cycles, unary 4, CLR 3, NOP/illegal 1.
//  Arithmetic modulo 2^N. Carry: ADD/INC carry-out; SUB/DEC borrow (A<B / A==0); SHL bit N-1 out; SHR bit 0 out;
//   all logic/MOV/CLR Carry=0. Zero = (result==0); for NOP, flags unchanged.
//  Start while Busy ignored (no queueing); OpCode changes after acceptance have no effect.
//  srcA==srcB or dst==src legal: reads complete before write, so in-place ops read old value.
//  Back-to-back: Start held high re-accepts in IDLE the cycle after DONE.
//  Bus contention: executor never drives MemoryData with RW=0; the RW=1 cycle is the only drive cycle.
// STRUCTURE
//  Package mem_op_executor_pkg: op_e enum (NOP..CLR), state_e enum, is_unary()/needs_read() functions,
//   opcode field slice localparams expressed in M.
//  Sub-module exec_alu #(N): pure combinational (op, a, b) -> (result, carry, zero); FSM/bus logic in top.
// TESTING (N=8, M=2, mem={0x0F,0xF1,0x80,0x00})
//  ADD dst=3,A=0,B=1 -> mem[3]=0x00, Carry=1, Zero=1, Done 5 cycles after Start, one RW=1 cycle at Select=3.
//  SUB dst=0,A=3(0x00),B=0 -> mem[0]=0xF1, Carry=1 (borrow), Zero=0; then SHL A=2,dst=2 -> 0x00, Carry=1, 4 cycles.
//  Op 0xE -> Done+Error after 1 cycle, no RW=1, memory unchanged, flags unchanged; NOP same with Error=0.
//  Start pulsed during Busy -> ignored; Start held high -> ops back-to-back with exactly one IDLE cycle between.
//  ResetN low during WRITE state -> RW=0, bus 'z, Busy=0 at once; restart ADD completes correctly.
//  Bus check every cycle: MemoryData never driven by DUT while RW=0; INC dst=srcA=1 -> mem[1]=0xF2 (in-place).

Source files
------------

// File: rtl/mem_op_executor_pkg.sv
// Shared types and helpers for the memory micro-op executor.
// The opcode layout is {op[3:0], dst, srcA, srcB}, with each address field M bits wide.
package mem_op_executor_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
        OP_INC = 4'h8, OP_DEC = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
        OP_CLR = 4'hC
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_RDA, S_RDB, S_EXEC, S_WRITE, S_DONE
    } state_e;

    localparam int OPF_W = 4;

    function automatic int op_lsb(input int m);   return 3 * m; endfunction
    function automatic int dst_lsb(input int m);  return 2 * m; endfunction
    function automatic int srca_lsb(input int m); return m;     endfunction
    function automatic int srcb_lsb(input int m); return 0 * m; endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_CLR;
    endfunction

    function automatic logic is_unary(input logic [3:0] op);
        return op inside {OP_MOV, OP_NOT, OP_INC, OP_DEC, OP_SHL, OP_SHR};
    endfunction

    // True for every op that fetches at least operand A from memory.
    function automatic logic needs_read(input logic [3:0] op);
        return is_legal(op) && (op != OP_NOP) && (op != OP_CLR);
    endfunction

endpackage

// File: rtl/mem_op_executor_if.sv
// Sequencer-side control interface of the executor.
// Start is sampled only while idle; Busy then rises and Done pulses for one cycle at the end.
interface mem_op_executor_if #(parameter int M = 2);
    import mem_op_executor_pkg::*;

    localparam int OPW = OPF_W + 3 * M;

    logic           Start;
    logic [OPW-1:0] OpCode;
    logic           Busy;
    logic           Done;
    logic           Error;
    logic           Carry;
    logic           Zero;
    state_e         dbg_state;

    modport master (output Start, OpCode,
                    input  Busy, Done, Error, Carry, Zero, dbg_state);
    modport slave  (input  Start, OpCode,
                    output Busy, Done, Error, Carry, Zero, dbg_state);
endinterface

// File: rtl/mem_op_executor_exec_alu.sv
// Combinational ALU for the executor: (op, a, b) -> (result, carry, zero).
// Subtract and decrement report the borrow in carry; the shifts report the bit shifted out.
module exec_alu
    import mem_op_executor_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero
);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_MOV: result = a;
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[N-1:0];
                carry  = sum[N];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_INC: begin
                sum    = {1'b0, a} + {1'b0, ONE};
                result = sum[N-1:0];
                carry  = sum[N];
            end
            OP_DEC: begin
                result = a - ONE;
                carry  = (a == '0);
            end
            OP_SHL: begin
                result = {a[N-2:0], 1'b0};
                carry  = a[N-1];
            end
            OP_SHR: begin
                result = {1'b0, a[N-1:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
        zero = (result == '0);
    end
endmodule

// File: rtl/mem_op_executor.sv
// Micro-op executor: fetches up to two operands over the shared memory bus, runs the ALU
// and writes the result back. It drives MemoryData only during the single WRITE cycle.
module mem_op_executor
    import mem_op_executor_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 2
) (
    input  logic         Clock,
    input  logic         ResetN,
    mem_op_executor_if.slave ctl,
    output logic [M-1:0] MemorySelect,
    inout  wire  [N-1:0] MemoryData,
    output logic         MemoryRW
);
    localparam int OP_LSB   = op_lsb(M);
    localparam int DST_LSB  = dst_lsb(M);
    localparam int SRCA_LSB = srca_lsb(M);
    localparam int SRCB_LSB = srcb_lsb(M);

    state_e       state;
    logic [3:0]   op_q;
    logic [M-1:0] dst_q, srca_q, srcb_q;
    logic [N-1:0] reg_a, reg_b, res_q;
    logic         c_q, z_q;
    logic         busy_q, done_q, err_q, carry_q, zero_q;

    logic [3:0]   in_op;
    logic [M-1:0] in_dst, in_a, in_b;
    logic [N-1:0] alu_res;
    logic         alu_c, alu_z;

    assign in_op  = ctl.OpCode[OP_LSB +: OPF_W];
    assign in_dst = ctl.OpCode[DST_LSB +: M];
    assign in_a   = ctl.OpCode[SRCA_LSB +: M];
    assign in_b   = ctl.OpCode[SRCB_LSB +: M];

    exec_alu #(.N(N)) u_alu (
        .op     (op_q),
        .a      (reg_a),
        .b      (reg_b),
        .result (alu_res),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state        <= S_IDLE;
            op_q         <= '0;
            dst_q        <= '0;
            srca_q       <= '0;
            srcb_q       <= '0;
            reg_a        <= '0;
            reg_b        <= '0;
            res_q        <= '0;
            c_q          <= 1'b0;
            z_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            MemorySelect <= '0;
            MemoryRW     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            MemoryRW <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctl.Start) begin
                        op_q   <= in_op;
                        dst_q  <= in_dst;
                        srca_q <= in_a;
                        srcb_q <= in_b;
                        busy_q <= 1'b1;
                        // NOP and illegal ops finish at once; flags are left untouched.
                        if (!is_legal(in_op) || in_op == OP_NOP) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            err_q  <= !is_legal(in_op);
                        end else if (!needs_read(in_op)) begin
                            state <= S_EXEC;
                        end else begin
                            state        <= S_RDA;
                            MemorySelect <= in_a;
                        end
                    end
                end
                S_RDA: begin
                    reg_a <= MemoryData;
                    if (is_unary(op_q)) begin
                        state <= S_EXEC;
                    end else begin
                        state        <= S_RDB;
                        MemorySelect <= srcb_q;
                    end
                end
                S_RDB: begin
                    reg_b <= MemoryData;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res_q        <= alu_res;
                    c_q          <= alu_c;
                    z_q          <= alu_z;
                    MemorySelect <= dst_q;
                    MemoryRW     <= 1'b1;
                    state        <= S_WRITE;
                end
                S_WRITE: begin
                    state   <= S_DONE;
                    done_q  <= 1'b1;
                    carry_q <= c_q;
                    zero_q  <= z_q;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign MemoryData    = (state == S_WRITE) ? res_q : 'z;
    assign ctl.Busy      = busy_q;
    assign ctl.Done      = done_q;
    assign ctl.Error     = err_q;
    assign ctl.Carry     = carry_q;
    assign ctl.Zero      = zero_q;
    assign ctl.dbg_state = state;
endmodule
